// File: rtl/dcache_dram_arbiter.sv
// Two-port arbiter sharing the single-port dcache data RAM between the core LSU
// and the refill/evict engine, with fill burst locking and core anti-starvation.
module dcache_dram_arbiter #(
  parameter int NUM_COL      = 16,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [NUM_COL-1:0]    c_wr_en,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  f_valid,
  input  logic                  f_lock,
  output logic                  f_ready,
  input  logic [NUM_COL-1:0]    f_wr_en,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  ram_req,
  output logic [NUM_COL-1:0]    ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             lock_q, lock_d;
  logic             c_rvalid_q, f_rvalid_q;
  logic             gnt_c, gnt_f;

  // Fill has default priority; an unlocked fill yields once the core has starved.
  assign gnt_f   = f_valid & (lock_q | ~c_valid | (starve_cnt_q < LIMIT_C));
  assign gnt_c   = c_valid & ~gnt_f;
  assign c_ready = gnt_c;
  assign f_ready = gnt_f;

  always_comb begin
    ram_req   = gnt_c | gnt_f;
    ram_wr_en = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_f) begin
      ram_wr_en = f_wr_en;
      ram_addr  = f_addr;
      ram_wdata = f_wdata;
    end else if (gnt_c) begin
      ram_wr_en = c_wr_en;
      ram_addr  = c_addr;
      ram_wdata = c_wdata;
    end
  end

  always_comb begin
    lock_d       = f_valid & f_lock & gnt_f;
    starve_cnt_d = starve_cnt_q;
    if (!c_valid || gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      lock_q       <= 1'b0;
      c_rvalid_q   <= 1'b0;
      f_rvalid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lock_q       <= lock_d;
      c_rvalid_q   <= gnt_c;
      f_rvalid_q   <= gnt_f;
    end
  end

  // RAM read data is shared; each side qualifies it with its own rvalid.
  assign c_rvalid = c_rvalid_q;
  assign f_rvalid = f_rvalid_q;
  assign c_rdata  = ram_rdata;
  assign f_rdata  = ram_rdata;

endmodule

// File: tb/tb_dcache_dram_arbiter.sv
// Directed table-driven bench for dcache_dram_arbiter with a behavioural
// write-through data RAM attached to the ram_* pins.
module tb_dcache_dram_arbiter;

  localparam int NC = 16;
  localparam int AW = 5;
  localparam int DW = 128;

  logic          clk, rst_n;
  logic          c_valid, c_ready, c_rvalid;
  logic [NC-1:0] c_wr_en;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          f_valid, f_lock, f_ready, f_rvalid;
  logic [NC-1:0] f_wr_en;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata, f_rdata;
  logic          ram_req;
  logic [NC-1:0] ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  dcache_dram_arbiter #(
    .NUM_COL(16), .COL_WIDTH(8), .ADDR_WIDTH(5), .DATA_WIDTH(128), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_wr_en(c_wr_en), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .f_valid(f_valid), .f_lock(f_lock), .f_ready(f_ready), .f_wr_en(f_wr_en),
    .f_addr(f_addr), .f_wdata(f_wdata), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .ram_req(ram_req), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_init(input logic [AW-1:0] a);
    return {NC{3'b101, a}};
  endfunction

  // Behavioural single-port RAM: 1-cycle read, write-through of merged line.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_req) begin
      logic [DW-1:0] nl;
      nl = mem[ram_addr];
      for (int i = 0; i < NC; i++)
        if (ram_wr_en[i]) nl[i*8 +: 8] = ram_wdata[i*8 +: 8];
      mem[ram_addr] <= nl;
      ram_rdata     <= nl;
    end
  end

  typedef struct {
    logic          cv;
    logic [NC-1:0] cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    logic          fv;
    logic          fl;
    logic [NC-1:0] fwe;
    logic [AW-1:0] fa;
    logic [DW-1:0] fwd;
    logic          ecr, efr, ereq;
    logic [NC-1:0] ewe;
    logic [AW-1:0] eaddr;
    logic          ecrv, efrv;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [NC-1:0] cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cwd, input logic fv, input logic fl,
                       input logic [NC-1:0] fwe, input logic [AW-1:0] fa, input logic [DW-1:0] fwd);
    @(negedge clk);
    c_valid = cv; c_wr_en = cwe; c_addr = ca; c_wdata = cwd;
    f_valid = fv; f_lock = fl;   f_wr_en = fwe; f_addr = fa; f_wdata = fwd;
    #1;
  endtask

  task automatic drive_both(input logic fl);
    drive(1'b1, '0, 5'd1, '0, 1'b1, fl, '0, 5'd2, '0);
  endtask

  logic [DW-1:0] A, W, M;
  logic          prev_c, prev_f, exp_c;

  initial begin
    A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    W = {NC{8'h5A}};
    M = {{8{3'b101, 5'd9}}, {8{8'h5A}}};
    for (int i = 0; i < 32; i++) mem[i] = line_init(5'(i));
    ram_rdata = '0;

    //          cv  cwe       ca     cwd  fv  fl  fwe       fa     fwd  ecr efr req ewe        eaddr  crv frv erd
    vecs[0] = '{1'b1, 16'h0,    5'd3, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 1'b1, 16'h0,    5'd3, 1'b0, 1'b0, '0};
    vecs[1] = '{1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 16'hFFFF, 5'd7, A,  1'b0, 1'b1, 1'b1, 16'hFFFF, 5'd7, 1'b1, 1'b0, line_init(5'd3)};
    vecs[2] = '{1'b1, 16'h0,    5'd7, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 1'b1, 16'h0,    5'd7, 1'b0, 1'b1, A};
    vecs[3] = '{1'b1, 16'h00FF, 5'd9, W,  1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 1'b1, 16'h00FF, 5'd9, 1'b1, 1'b0, A};
    vecs[4] = '{1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 1'b0, 16'h0,    5'd0, 1'b1, 1'b0, M};
    vecs[5] = '{1'b1, 16'h0,    5'd9, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 1'b1, 16'h0,    5'd9, 1'b0, 1'b0, '0};
    vecs[6] = '{1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 1'b0, 16'h0,    5'd0, 1'b1, 1'b0, M};
    vecs[7] = '{1'b0, 16'h0,    5'd0, '0, 1'b1, 1'b0, 16'h0,    5'd3, '0, 1'b0, 1'b1, 1'b1, 16'h0,    5'd3, 1'b0, 1'b0, '0};
    vecs[8] = '{1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 16'h0,    5'd0, '0, 1'b0, 1'b0, 1'b0, 16'h0,    5'd0, 1'b0, 1'b1, line_init(5'd3)};

    // Reset with both requesters valid
    rst_n = 1'b0;
    drive_both(1'b0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_f_ready", f_ready, 1);
    chk("rst_c_ready", c_ready, 0);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("post_rst_f_rvalid", f_rvalid, 1);
    chk("post_rst_c_rvalid", c_rvalid, 0);
    chk("post_rst_rdata", f_rdata, line_init(5'd2));

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].cv, vecs[v].cwe, vecs[v].ca, vecs[v].cwd,
            vecs[v].fv, vecs[v].fl, vecs[v].fwe, vecs[v].fa, vecs[v].fwd);
      chk($sformatf("v%0d_c_ready", v), c_ready, vecs[v].ecr);
      chk($sformatf("v%0d_f_ready", v), f_ready, vecs[v].efr);
      chk($sformatf("v%0d_ram_req", v), ram_req, vecs[v].ereq);
      chk($sformatf("v%0d_ram_wr_en", v), ram_wr_en, vecs[v].ewe);
      if (vecs[v].ereq) chk($sformatf("v%0d_ram_addr", v), ram_addr, vecs[v].eaddr);
      if (vecs[v].ewe != '0)
        chk($sformatf("v%0d_ram_wdata", v), ram_wdata, vecs[v].efr ? vecs[v].fwd : vecs[v].cwd);
      chk($sformatf("v%0d_c_rvalid", v), c_rvalid, vecs[v].ecrv);
      chk($sformatf("v%0d_f_rvalid", v), f_rvalid, vecs[v].efrv);
      if (vecs[v].ecrv) chk($sformatf("v%0d_c_rdata", v), c_rdata, vecs[v].erd);
      if (vecs[v].efrv) chk($sformatf("v%0d_f_rdata", v), f_rdata, vecs[v].erd);
    end

    // Unlocked contention: fill 4 cycles, core on the 5th, repeat
    prev_c = 1'b0; prev_f = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_both(1'b0);
      exp_c = (k % 5 == 4);
      chk($sformatf("cont%0d_c_ready", k), c_ready, exp_c);
      chk($sformatf("cont%0d_f_ready", k), f_ready, !exp_c);
      chk($sformatf("cont%0d_c_rvalid", k), c_rvalid, prev_c);
      chk($sformatf("cont%0d_f_rvalid", k), f_rvalid, prev_f);
      prev_c = exp_c; prev_f = !exp_c;
    end

    // Locked burst of 8 beats starves the core past the limit
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      drive_both(1'b1);
      chk($sformatf("lock%0d_c_ready", k), c_ready, 0);
      chk($sformatf("lock%0d_f_ready", k), f_ready, 1);
    end
    drive_both(1'b0);
    chk("unlock_beat_f_ready", f_ready, 1);
    drive_both(1'b0);
    chk("after_lock_c_ready", c_ready, 1);
    chk("after_lock_f_ready", f_ready, 0);
    drive_both(1'b0);
    chk("after_core_f_ready", f_ready, 1);

    // Reset in the middle of a locked fill burst with saturated starvation
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 6; k++) drive_both(1'b1);
    @(posedge clk);
    #1;
    chk("lockrst_f_rvalid_before", f_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lockrst_f_rvalid_async", f_rvalid, 0);
    drive_both(1'b0);
    chk("lockrst_f_ready_in_rst", f_ready, 1);
    rst_n = 1'b1;
    for (int k = 1; k < 6; k++) begin
      drive_both(1'b0);
      chk($sformatf("lockrst%0d_c_ready", k), c_ready, (k == 4));
    end

    // Reset in the middle of a core access
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, '0, 5'd3, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("crst_c_ready", c_ready, 1);
    @(posedge clk);
    #1;
    chk("crst_c_rvalid_before", c_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("crst_c_rvalid_async", c_rvalid, 0);
    chk("crst_f_rvalid_async", f_rvalid, 0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("crst_c_rvalid_after", c_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
